warp_ibuf: RTL and testbench

Instruction buffer between the fetch stage and decode. Accepts a packet of one or two instructions per cycle from fetch over a valid/ready handshake. Stores the instructions individually in a circular queue and presents up to two of the oldest to decode each cycle. Decouples fetch-side cache stalls from decode-side backpressure and supports a single-cycle flush on redirect.

---
 rtl/warp_ibuf.sv | 92 +++++++++
 tb/tb_warp_ibuf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/warp_ibuf.sv
// warp_ibuf: fetch-to-decode instruction buffer.
// Takes one or two instructions per cycle from fetch, keeps them one per entry
// in a circular queue, and shows the two oldest to decode.
module warp_ibuf #(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_input_valid,
   output logic          o_input_ready,
   input  logic [31:0]   i_inst0,
   input  logic [31:0]   i_inst1,
   input  logic [1:0]    i_compressed,
   input  logic          i_count,
   input  logic          i_flush,
   output logic [1:0]    o_valid,
   output logic [31:0]   o_inst0,
   output logic [31:0]   o_inst1,
   output logic [1:0]    o_compressed,
   input  logic [1:0]    i_deq,
   output logic [PW:0]   o_occupancy
);

   // Each entry holds {compressed flag, 32-bit instruction}.
   typedef logic [32:0] entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   occ_q, occ_d;

   logic          ready;
   logic          accept;
   logic [1:0]    enq_n, deq_n;
   logic [PW-1:0] wr_p1, rd_p1;

   // Readiness looks only at registered occupancy and never credits a
   // same-cycle dequeue; held low while reset is asserted.
   assign ready  = !i_rst && (occ_q <= (PW+1)'(DEPTH - 2));
   assign accept = i_input_valid && ready && !i_flush;
   assign wr_p1  = wr_ptr_q + PW'(1);
   assign rd_p1  = rd_ptr_q + PW'(1);

   // Next-state pointers and occupancy; flush wins over enqueue and dequeue.
   always_comb begin
      enq_n    = accept ? (i_count ? 2'd2 : 2'd1) : 2'd0;
      deq_n    = 2'(i_deq[0]) + 2'(i_deq[1]);
      rd_ptr_d = rd_ptr_q + PW'(deq_n);
      wr_ptr_d = wr_ptr_q + PW'(enq_n);
      occ_d    = occ_q + (PW+1)'(enq_n) - (PW+1)'(deq_n);
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage: inst0 at wr_ptr, inst1 at the following (wrapped) slot.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (accept) begin
         mem_q[wr_ptr_q] <= {i_compressed[0], i_inst0};
         if (i_count) mem_q[wr_p1] <= {i_compressed[1], i_inst1};
      end
   end

   // Read side: no bypass, slots show stale data when not valid.
   always_comb begin
      o_input_ready = ready;
      o_valid       = {occ_q >= (PW+1)'(2), occ_q >= (PW+1)'(1)};
      o_inst0       = mem_q[rd_ptr_q][31:0];
      o_inst1       = mem_q[rd_p1][31:0];
      o_compressed  = {mem_q[rd_p1][32], mem_q[rd_ptr_q][32]};
      o_occupancy   = occ_q;
   end

endmodule

// File: tb/tb_warp_ibuf.sv
// tb_warp_ibuf: directed scenarios plus random traffic against a queue model.
module tb_warp_ibuf;
   localparam int DEPTH = 8;
   localparam int PW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [31:0]   inst0, inst1, o_inst0, o_inst1;
   logic [1:0]    comp, o_comp, o_valid, deq;
   logic          cnt, flush;
   logic [PW:0]   occ;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: a plain FIFO of {compressed, inst}.
   logic [32:0] q[$];

   always #5 clk = ~clk;

   warp_ibuf #(.DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_input_valid(in_valid), .o_input_ready(in_ready),
      .i_inst0(inst0), .i_inst1(inst1), .i_compressed(comp), .i_count(cnt),
      .i_flush(flush),
      .o_valid(o_valid), .o_inst0(o_inst0), .o_inst1(o_inst1),
      .o_compressed(o_comp), .i_deq(deq), .o_occupancy(occ)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Compare every observable output against the model.
   task automatic cmp_all();
      int n;
      logic [1:0] ev;
      n  = q.size();
      ev = (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      chk("occ", 64'(occ), 64'(n));
      chk("ready", 64'(in_ready), 64'(DEPTH - n >= 2));
      chk("valid", 64'(o_valid), 64'(ev));
      if (n >= 1) begin
         chk("inst0", 64'(o_inst0), 64'(q[0][31:0]));
         chk("comp0", 64'(o_comp[0]), 64'(q[0][32]));
      end
      if (n >= 2) begin
         chk("inst1", 64'(o_inst1), 64'(q[1][31:0]));
         chk("comp1", 64'(o_comp[1]), 64'(q[1][32]));
      end
   endtask

   // One clock: drive at negedge, update model, compare at next negedge.
   task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] c, input logic k, input logic [1:0] d,
                      input logic f);
      int dn;
      in_valid = v; inst0 = a; inst1 = b; comp = c; cnt = k; deq = d; flush = f;
      chk("deq_proto", 64'(deq & ~o_valid), 64'd0);
      if (f) q.delete();
      else begin
         dn = int'(d[0]) + int'(d[1]);
         if (v && (DEPTH - q.size() >= 2)) begin
            for (int i = 0; i < dn; i++) void'(q.pop_front());
            q.push_back({c[0], a});
            if (k) q.push_back({c[1], b});
         end else begin
            for (int i = 0; i < dn; i++) void'(q.pop_front());
         end
      end
      @(posedge clk);
      @(negedge clk);
      cmp_all();
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0);
   endtask

   initial begin
      logic [31:0] seq;
      int r;
      in_valid = 0; inst0 = 0; inst1 = 0; comp = 0; cnt = 0; deq = 0; flush = 0;
      rst = 1'b1;
      #12;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_occ", 64'(occ), 64'd0);
      chk("rst_inst0", 64'(o_inst0), 64'd0);
      chk("rst_comp", 64'(o_comp), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      cmp_all();

      // First two-instruction packet, visible one cycle later.
      cyc(1'b1, 32'h00000013, 32'h00100093, 2'b00, 1'b1, 2'b00, 1'b0);
      chk("tp1_inst0", 64'(o_inst0), 64'h13);
      chk("tp1_inst1", 64'(o_inst1), 64'h00100093);
      cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b11, 1'b0);

      // Fill to DEPTH, extra packet refused, drain back to ready.
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 2'(i), 1'b1, 2'b00, 1'b0);
      chk("full_occ", 64'(occ), 64'd8);
      chk("full_rdy", 64'(in_ready), 64'd0);
      cyc(1'b1, 32'hdead, 32'hbeef, 2'b00, 1'b1, 2'b00, 1'b0);
      cyc(1'b1, 32'hdead, 32'hbeef, 2'b00, 1'b1, 2'b01, 1'b0);
      chk("occ7", 64'(occ), 64'd7);
      chk("occ7_rdy", 64'(in_ready), 64'd0);
      cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b11, 1'b0);
      chk("occ5", 64'(occ), 64'd5);
      chk("occ5_rdy", 64'(in_ready), 64'd1);
      cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b1);

      // Single compressed instructions at one per cycle.
      cyc(1'b1, 32'h00004501, 32'h0, 2'b01, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 32'h00004501, 32'h0, 2'b01, 1'b0, 2'b01, 1'b0);
      chk("stream_occ", 64'(occ), 64'd1);
      chk("stream_valid", 64'(o_valid), 64'd1);
      chk("stream_comp", 64'(o_comp[0]), 64'd1);
      cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b01, 1'b0);

      // Wrap-around with incrementing payloads.
      seq = 32'h1000;
      cyc(1'b1, seq, seq + 1, 2'b00, 1'b1, 2'b00, 1'b0);
      seq += 2;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, seq, seq + 1, 2'b10, 1'b1, 2'b11, 1'b0);
         seq += 2;
      end
      cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b11, 1'b0);

      // Flush at occupancy 5 with a valid packet in the same cycle.
      cyc(1'b1, 32'h2000, 32'h2001, 2'b00, 1'b1, 2'b00, 1'b0);
      cyc(1'b1, 32'h2002, 32'h2003, 2'b00, 1'b1, 2'b00, 1'b0);
      cyc(1'b1, 32'h2004, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0);
      chk("pre_flush_occ", 64'(occ), 64'd5);
      cyc(1'b1, 32'h2bad, 32'h2bad, 2'b00, 1'b1, 2'b00, 1'b1);
      chk("flush_valid", 64'(o_valid), 64'd0);
      chk("flush_rdy", 64'(in_ready), 64'd1);
      idle();

      // Async reset mid-stream at occupancy 3.
      cyc(1'b1, 32'h3000, 32'h3001, 2'b11, 1'b1, 2'b00, 1'b0);
      cyc(1'b1, 32'h3002, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0);
      chk("pre_rst_occ", 64'(occ), 64'd3);
      in_valid = 0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(o_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_occ", 64'(occ), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      #1;
      cmp_all();
      cyc(1'b1, 32'h4000, 32'h4001, 2'b01, 1'b1, 2'b00, 1'b0);
      chk("post_rst_inst0", 64'(o_inst0), 64'h4000);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [1:0] d;
         r = $urandom_range(0, 2);
         if (r > q.size()) r = q.size();
         d = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
         cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 2'($urandom),
             1'($urandom), d, 1'($urandom_range(0, 24) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1);
   end
endmodule
